// File: rtl/tx_pulse_con.sv
// Transmit pulse controller.
// Holds a per-channel focusing delay table. On fire, every enabled channel
// emits a bipolar burst (PULSE_CYCLES periods, HALF_PERIOD clocks per half)
// starting after its own delay. The event always lasts T_LAST+1 cycles,
// independent of the table contents, so the receive path can be armed from done.
module tx_pulse_con #(
  parameter int NUM_CHANNELS = 16,
  parameter int DELAY_WIDTH  = 8,
  parameter int PULSE_CYCLES = 2,
  parameter int HALF_PERIOD  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_CHANNELS)-1:0] cfg_addr,
  input  logic [DELAY_WIDTH-1:0]          cfg_delay,
  input  logic [NUM_CHANNELS-1:0]         ch_mask,
  input  logic                            fire,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_CHANNELS-1:0]         tx_en,
  output logic [NUM_CHANNELS-1:0]         tx_p,
  output logic [NUM_CHANNELS-1:0]         tx_n
);

  localparam int PULSE_LEN = 2 * PULSE_CYCLES * HALF_PERIOD;
  localparam int T_LAST    = (1 << DELAY_WIDTH) - 1 + PULSE_LEN;
  // Wide enough for the largest delay plus a full burst, so ph never wraps.
  localparam int T_W       = $clog2(T_LAST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [T_W-1:0]          t_q, t_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [NUM_CHANNELS-1:0] tx_en_q, tx_en_d;
  logic [NUM_CHANNELS-1:0] tx_p_q, tx_p_d;
  logic [NUM_CHANNELS-1:0] tx_n_q, tx_n_d;

  logic [DELAY_WIDTH-1:0]  dly_tbl_q [NUM_CHANNELS];
  logic                    tbl_we;

  // Burst-window decode for the current count, one copy per channel.
  logic [NUM_CHANNELS-1:0] win_en, win_p, win_n;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [T_W-1:0] dly;
    logic [T_W-1:0] ph;
    logic           in_win;
    logic           odd_half;

    assign dly      = T_W'(dly_tbl_q[i]);
    assign ph       = t_q - dly;
    assign in_win   = mask_q[i] && (t_q >= dly) && (ph < T_W'(PULSE_LEN));
    assign odd_half = ((ph / T_W'(HALF_PERIOD)) % T_W'(2)) != '0;
    assign win_en[i] = in_win;
    assign win_p[i]  = in_win && !odd_half;
    assign win_n[i]  = in_win &&  odd_half;
  end

  // The table only accepts writes while idle, so a running event never
  // sees its delays change underneath it.
  assign tbl_we = (state_q == IDLE) && cfg_we && (int'(cfg_addr) < NUM_CHANNELS);

  // Delay table storage.
  always_ff @(posedge clk) begin
    // NOTE: the table is cleared on reset because a post-reset fire must
    // burst every unmasked channel at delay 0; without this, stale delays
    // would survive reset and the flops would power up undefined.
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        dly_tbl_q[i] <= '0;
      end
    end else if (tbl_we) begin
      dly_tbl_q[cfg_addr] <= cfg_delay;
    end
  end

  // State, counter, sampled mask and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the
    // pre-edge values; blocking here would let later lines see new values.
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_en_q <= '0;
      tx_p_q  <= '0;
      tx_n_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_en_q <= tx_en_d;
      tx_p_q  <= tx_p_d;
      tx_n_q  <= tx_n_d;
    end
  end

  // Next-state and next-output logic; outputs default low each cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    t_d     = t_q;
    mask_d  = mask_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    tx_en_d = '0;
    tx_p_d  = '0;
    tx_n_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = RUN;
          t_d     = '0;
          mask_d  = ch_mask;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          // Outputs and busy already default low; no done on abort.
          state_d = IDLE;
        end else if (t_q == T_W'(T_LAST)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          t_d     = t_q + T_W'(1);
          busy_d  = 1'b1;
          tx_en_d = win_en;
          tx_p_d  = win_p;
          tx_n_d  = win_n;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign tx_en = tx_en_q;
  assign tx_p  = tx_p_q;
  assign tx_n  = tx_n_q;

endmodule

// File: doc/tx_pulse_con.md
Name: tx_pulse_con

Overview:
- Transmit-side counterpart of the receive delay/beamform controller: holds a per-channel transmit focusing delay table and, on a fire command, drives each channel's bipolar pulser after that channel's delay.
- Sits between the acquisition sequencer (config writes, fire) and the per-channel pulser drivers.
- The receive path is armed from `done`.

Parameters:
- NUM_CHANNELS, 16, number of transducer channels.
- DELAY_WIDTH, 8, bits per channel delay in clk cycles; maximum delay is 2^DELAY_WIDTH-1.
- PULSE_CYCLES, 2, number of full bipolar periods per burst.
- HALF_PERIOD, 2, clk cycles per pulse half-period.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  delay table write strobe.
- cfg_addr  in  $clog2(NUM_CHANNELS)  channel index for the write.
- cfg_delay  in  DELAY_WIDTH  delay value for the write.
- ch_mask  in  NUM_CHANNELS  per-channel enable; sampled when fire is accepted.
- fire  in  1  start a transmit event.
- abort  in  1  terminate an event in progress.
- busy  out  1  high while an event is in progress.
- done  out  1  one-cycle pulse when an event completes normally.
- tx_en  out  NUM_CHANNELS  channel is inside its burst window.
- tx_p  out  NUM_CHANNELS  positive pulser drive.
- tx_n  out  NUM_CHANNELS  negative pulser drive.

Behaviour:
- Clock clk; reset is synchronous, active-high. All state is sampled on the rising edge.
- Reset values:
  - state = IDLE, busy = 0, done = 0.
  - tx_en, tx_p, tx_n all 0.
  - Delay table all 0; mask register 0; counter t = 0.
- Reset mid-event forces all outputs low at that same edge.
- Derived constants:
  - PULSE_LEN = 2*PULSE_CYCLES*HALF_PERIOD.
  - T_LAST = 2^DELAY_WIDTH - 1 + PULSE_LEN.
  - Counter t is wide enough to hold T_LAST.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_we writes table[cfg_addr] <= cfg_delay. Writes in any other state are ignored.
  - fire=1 moves to RUN, sets t <= 0, mask_r <= ch_mask, busy <= 1.
  - cfg_we and fire on the same edge: the write takes effect and the event uses the new value.
- RUN:
  - Each edge: t <= t+1, and outputs are registered from the current t.
  - For channel i, with ph = t - table[i]:
    - tx_en[i] = mask_r[i] && t >= table[i] && ph < PULSE_LEN.
    - tx_p[i] = tx_en[i] && (ph / HALF_PERIOD) is even.
    - tx_n[i] = tx_en[i] && (ph / HALF_PERIOD) is odd.
  - Latency: fire is sampled at edge E0. A channel with delay d raises tx_en and tx_p after edge E(d+1). The window lasts exactly PULSE_LEN cycles, and tx_n first rises HALF_PERIOD cycles after tx_p.
  - On the edge where t == T_LAST: outputs are cleared and state moves to DONE.
  - abort=1 in RUN: at that edge all outputs are cleared, busy <= 0, state moves to IDLE, and done is not asserted.
  - fire in RUN or DONE is ignored.
- DONE:
  - done = 1 for exactly one cycle and busy = 0 in that cycle.
  - Next edge: return to IDLE.
  - abort in DONE has no effect.
- Invariants:
  - tx_p[i] and tx_n[i] are never both 1.
  - No output toggles while in IDLE.
  - Event length is fixed regardless of table contents: done rises after edge E(T_LAST+1).
- Arithmetic: all compares are unsigned. The delay plus pulse window never wraps, because the counter width covers T_LAST.

Test Plan:
1. Defaults (PULSE_LEN=8, T_LAST=263).
   - Stimulus: write ch0=0, ch1=5, ch15=255; mask all 1; fire.
   - Required: tx_p[0] high after E1–E2, tx_n[0] high after E3–E4, repeat once. ch1 is the same pattern starting at E6. ch15 starts at E256. done is a single cycle after E264; busy is high E1–E263.
2. Write ch3=10 on the same cycle fire is asserted → ch3 bursts starting at E11 (new value used).
3. Mask bit 2 = 0 with ch2=0 → tx_en/tx_p/tx_n[2] stay 0 for the whole event; other channels unaffected.
4. Abort at E5 with ch0=0 → all outputs 0 after E5; busy falls; done never asserts.
   - A cfg write one cycle later succeeds.
   - A fresh fire then produces a full event.
5. Reset asserted mid-burst at E3 → outputs 0 after E3, table reads 0; a subsequent fire bursts all unmasked channels from E1.
6. fire and cfg_we pulsed during RUN → ignored; table unchanged and event timing unchanged. Throughout all tests, assert tx_p & tx_n == 0 every cycle.
